// File: rtl/sdram_pkg.sv
// Shared SDRAM arbiter definitions: bus widths, state encoding and command codes.
package sdram_pkg;
  localparam int CMD_W  = 4;
  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_e;

  // Commands are {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [BA_W-1:0]   ba;
  } sdram_bus_t;

  localparam sdram_bus_t BUS_NOP = '{cmd: CMD_NOP, addr: '0, ba: '0};
endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval counter; pulses wrap on the last count while enabled.
module sdram_ref_timer #(
  parameter int REF_CYCLES = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic wrap
);
  localparam int CW = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REF_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    if (en) count_d = wrap ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter between init, refresh, write and read masters.
// Define SDRAM_ARB_RR_EN to alternate write/read on simultaneous requests.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int REF_CYCLES = 780
) (
  input  logic              sysclk_100M,
  input  logic              rst,
  input  logic              init_done,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  output logic              aref_en,
  input  logic              aref_end,
  input  logic [CMD_W-1:0]  aref_cmd,
  input  logic              wr_req,
  output logic              wr_en,
  input  logic              wr_end,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic              rd_req,
  output logic              rd_en,
  input  logic              rd_end,
  input  logic [CMD_W-1:0]  rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_ba,
  output logic              ref_pending,
  output logic [CMD_W-1:0]  cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [BA_W-1:0]   ba
);
  state_e     state_q, state_d, tie_st;
  logic       ref_pending_q, ref_pending_d;
  logic       aref_en_q, aref_en_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  logic       ref_wrap;
  sdram_bus_t bus_q, bus_d;

  sdram_ref_timer #(.REF_CYCLES(REF_CYCLES)) u_ref_timer (
    .clk  (sysclk_100M),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .wrap (ref_wrap)
  );

`ifdef SDRAM_ARB_RR_EN
  // Remembers the last data master served; resets as "read" so write wins the first tie.
  logic last_wr_q, last_wr_d;

  always_comb begin
    tie_st    = last_wr_q ? ST_READ : ST_WRITE;
    last_wr_d = last_wr_q;
    if (wr_en_d) last_wr_d = 1'b1;
    if (rd_en_d) last_wr_d = 1'b0;
  end

  always_ff @(posedge sysclk_100M) begin
    if (rst) last_wr_q <= 1'b0;
    else     last_wr_q <= last_wr_d;
  end
`else
  always_comb tie_st = ST_WRITE;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (init_done) state_d = ST_ARB;
      ST_ARB: begin
        if (ref_pending_q)        state_d = ST_AREF;
        else if (wr_req && rd_req) state_d = tie_st;
        else if (wr_req)          state_d = ST_WRITE;
        else if (rd_req)          state_d = ST_READ;
      end
      ST_AREF:  if (aref_end) state_d = ST_ARB;
      ST_WRITE: if (wr_end)   state_d = ST_ARB;
      ST_READ:  if (rd_end)   state_d = ST_ARB;
      default:  state_d = ST_IDLE;
    endcase

    aref_en_d = (state_q == ST_ARB) && (state_d == ST_AREF);
    wr_en_d   = (state_q == ST_ARB) && (state_d == ST_WRITE);
    rd_en_d   = (state_q == ST_ARB) && (state_d == ST_READ);

    // A granted refresh absorbs any wrap seen meanwhile; missed intervals are not queued.
    ref_pending_d = aref_en_d ? 1'b0 : (ref_pending_q | ref_wrap);

    // Any cycle landing in ARB (including a master's return) shows NOP.
    bus_d = BUS_NOP;
    if (state_d != ST_ARB) begin
      case (state_q)
        ST_IDLE:  bus_d = '{cmd: init_cmd, addr: init_addr, ba: '0};
        ST_AREF:  bus_d = '{cmd: aref_cmd, addr: '0,        ba: '0};
        ST_WRITE: bus_d = '{cmd: wr_cmd,   addr: wr_addr,   ba: wr_ba};
        ST_READ:  bus_d = '{cmd: rd_cmd,   addr: rd_addr,   ba: rd_ba};
        default:  bus_d = BUS_NOP;
      endcase
    end
  end

  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ref_pending_q <= 1'b0;
      aref_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      bus_q         <= BUS_NOP;
    end else begin
      state_q       <= state_d;
      ref_pending_q <= ref_pending_d;
      aref_en_q     <= aref_en_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      bus_q         <= bus_d;
    end
  end

  assign aref_en     = aref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign ref_pending = ref_pending_q;
  assign cmd         = bus_q.cmd;
  assign addr        = bus_q.addr;
  assign ba          = bus_q.ba;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized scoreboard bench for sdram_arbiter against a transaction-level reference model.
module tb_sdram_arbiter;
  localparam int REF  = 20;
  localparam int NCYC = 4000;
  localparam int M_IDLE = 0, M_ARB = 1, M_AREF = 2, M_WR = 3, M_RD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, init_done, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [12:0] init_addr, wr_addr, rd_addr;
  logic [1:0]  wr_ba, rd_ba;
  logic        aref_en, wr_en, rd_en, ref_pending;
  logic [3:0]  cmd;
  logic [12:0] addr;
  logic [1:0]  ba;

  sdram_arbiter #(.REF_CYCLES(REF)) dut (
    .sysclk_100M(clk), .rst(rst), .init_done(init_done), .init_cmd(init_cmd),
    .init_addr(init_addr), .aref_en(aref_en), .aref_end(aref_end), .aref_cmd(aref_cmd),
    .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .wr_ba(wr_ba), .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end), .rd_cmd(rd_cmd),
    .rd_addr(rd_addr), .rd_ba(rd_ba), .ref_pending(ref_pending), .cmd(cmd), .addr(addr), .ba(ba)
  );

  typedef struct {
    bit        aref, wr, rd, pend;
    bit [3:0]  cmd;
    bit [12:0] addr;
    bit [1:0]  ba;
  } exp_t;

  exp_t bq[$];
  int   gq[$];
  int   checks = 0, failures = 0;

  // Reference state: who owns the bus, count of active (non-idle) cycles, pending flag.
  int mst = M_IDLE, act = 0;
  bit pend = 0, lastw = 0;
  // Master behaviour
  bit wreq_r = 0, rreq_r = 0;
  int wr_left = 0, rd_left = 0, af_left = 0, since_rst = 0, init_delay = 8, rst_hold = 0;

  task automatic chk(string name, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, a, e, $time);
    end
  endtask

  function automatic int pick();
    if (pend) return M_AREF;
    if (wr_req && rd_req) begin
`ifdef SDRAM_ARB_RR_EN
      return lastw ? M_RD : M_WR;
`else
      return M_WR;
`endif
    end
    if (wr_req) return M_WR;
    if (rd_req) return M_RD;
    return M_ARB;
  endfunction

  // Predicts what the DUT shows after the coming rising edge.
  task automatic model_step();
    exp_t e;
    int   nst, g;
    bit   wrap;
    e.aref = 0; e.wr = 0; e.rd = 0; e.pend = 0; e.cmd = 4'b0111; e.addr = '0; e.ba = '0;
    if (rst) begin
      mst = M_IDLE; act = 0; pend = 0; lastw = 0;
      bq.push_back(e);
      return;
    end
    wrap = (mst != M_IDLE) && ((act % REF) == REF - 1);
    if (mst != M_IDLE) act++;
    nst = mst; g = 0;
    case (mst)
      M_IDLE: if (init_done) nst = M_ARB;
      M_ARB:  begin nst = pick(); if (nst != M_ARB) g = nst; end
      M_AREF: if (aref_end) nst = M_ARB;
      M_WR:   if (wr_end) nst = M_ARB;
      M_RD:   if (rd_end) nst = M_ARB;
      default: nst = M_IDLE;
    endcase
    if (g == M_WR) lastw = 1;
    if (g == M_RD) lastw = 0;
    if (g == M_AREF) pend = 0;
    else if (wrap)   pend = 1;
    e.aref = (g == M_AREF); e.wr = (g == M_WR); e.rd = (g == M_RD); e.pend = pend;
    if (nst != M_ARB) begin
      case (mst)
        M_IDLE: begin e.cmd = init_cmd; e.addr = init_addr; end
        M_AREF: e.cmd = aref_cmd;
        M_WR:   begin e.cmd = wr_cmd; e.addr = wr_addr; e.ba = wr_ba; end
        M_RD:   begin e.cmd = rd_cmd; e.addr = rd_addr; e.ba = rd_ba; end
        default: ;
      endcase
    end
    if (g != 0) begin
      gq.push_back(g);
      case (g)
        M_AREF: af_left = $urandom_range(0, 3);
        M_WR: begin
          wr_left = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 6);
          wreq_r = 0;
        end
        default: begin
          rd_left = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 6);
          rreq_r = 0;
        end
      endcase
    end
    mst = nst;
    bq.push_back(e);
  endtask

  // Monitor: compares every presented cycle and the order of grant pulses.
  initial begin
    exp_t e;
    int   code;
    forever begin
      @(posedge clk); #1;
      if (bq.size() > 0) begin
        e = bq.pop_front();
        chk("aref_en", int'(aref_en), int'(e.aref));
        chk("wr_en", int'(wr_en), int'(e.wr));
        chk("rd_en", int'(rd_en), int'(e.rd));
        chk("ref_pending", int'(ref_pending), int'(e.pend));
        chk("cmd", int'(cmd), int'(e.cmd));
        chk("addr", int'(addr), int'(e.addr));
        chk("ba", int'(ba), int'(e.ba));
      end
      if ((aref_en | wr_en | rd_en) === 1'b1) begin
        code = aref_en ? M_AREF : (wr_en ? M_WR : M_RD);
        chk("grant_onehot", $countones({aref_en, wr_en, rd_en}), 1);
        if (gq.size() == 0) chk("grant_unexpected", code, 0);
        else                chk("grant_order", code, gq.pop_front());
      end
    end
  end

  // Driver: all inputs change on the falling edge.
  initial begin
    rst = 1; init_done = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
    init_cmd = 4'b0111; aref_cmd = 0; wr_cmd = 0; rd_cmd = 0;
    init_addr = 0; wr_addr = 0; rd_addr = 0; wr_ba = 0; rd_ba = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c < 3) rst = 1;
      else if (rst_hold > 0) begin rst = 1; rst_hold--; end
      else if ($urandom_range(0, (mst == M_RD) ? 149 : 599) == 0) begin
        rst = 1; rst_hold = $urandom_range(0, 1);
      end else rst = 0;
      if (rst) begin
        since_rst = 0; wreq_r = 0; rreq_r = 0;
        init_delay = (c < 3) ? 8 : $urandom_range(0, 8);
      end else since_rst++;
      init_done = !rst && (since_rst >= init_delay);
      init_cmd = 4'($urandom); init_addr = 13'($urandom);
      aref_cmd = 4'($urandom);
      wr_cmd = 4'($urandom); wr_addr = 13'($urandom); wr_ba = 2'($urandom);
      rd_cmd = 4'($urandom); rd_addr = 13'($urandom); rd_ba = 2'($urandom);
      if (!rst && !wreq_r && mst != M_WR && $urandom_range(0, 3) == 0) wreq_r = 1;
      if (!rst && !rreq_r && mst != M_RD && $urandom_range(0, 3) == 0) rreq_r = 1;
      wr_req = wreq_r; rd_req = rreq_r;
      if (mst == M_WR) begin wr_end = (wr_left == 0); if (wr_left > 0) wr_left--; end
      else wr_end = ($urandom_range(0, 15) == 0);
      if (mst == M_RD) begin rd_end = (rd_left == 0); if (rd_left > 0) rd_left--; end
      else rd_end = ($urandom_range(0, 15) == 0);
      if (mst == M_AREF) begin aref_end = (af_left == 0); if (af_left > 0) af_left--; end
      else aref_end = ($urandom_range(0, 15) == 0);
      model_step();
    end
    repeat (3) @(posedge clk);
    #2;
    chk("exp_queue_drained", bq.size(), 0);
    chk("grant_queue_drained", gq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
